aer_event_encoder: RTL and testbench
====================================

Name: aer_event_encoder

Overview:
- Consumer-side end of the pixel arbiter's grant interface.
- Samples the one-hot grant matrix and polarity bit each cycle, encodes the granted pixel into an address-event word {timestamp, x, y, polarity} and buffers it in a FIFO.
- Streams the buffered words downstream over a valid/ready handshake.
- Sits directly after the row/column arbiter and before the readout/serializer.

Parameters:
- ROWS, 8, pixel array rows (grant matrix first dimension).
- COLS, 8, pixel array columns (grant matrix second dimension).
- X_WIDTH, $clog2(ROWS), row address width.
- Y_WIDTH, $clog2(COLS), column address width.
- TS_WIDTH, 16, timestamp counter width.
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- EVT_WIDTH, TS_WIDTH+X_WIDTH+Y_WIDTH+1, event word width.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  capture and timestamp enable.
- gnt_i  input  [ROWS-1:0][COLS-1:0]  grant matrix from arbiter; one-hot or zero.
- polarity_i  input  1  polarity of the granted pixel, valid in the same cycle as gnt_i.
- evt_valid_o  output  1  event word available.
- evt_data_o  output  EVT_WIDTH  {ts[TS_WIDTH-1:0], x, y, pol}, MSB to LSB.
- evt_ready_i  input  1  downstream accepts the word.
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt_o  output  8  saturating count of events dropped because the FIFO was full.
- err_o  output  1  one-cycle pulse when gnt_i is multi-hot.
- ts_wrap_o  output  1  one-cycle pulse when the timestamp wraps.

Behaviour:
- Reset: reset_i low clears all registers asynchronously. FIFO empty; evt_valid_o=0, evt_data_o=0, fifo_count_o=0, drop_cnt_o=0, err_o=0, ts_wrap_o=0, timestamp=0. Reset mid-stream discards all buffered events.
- Timestamp: increments by 1 on each clock edge while enable_i=1 and holds otherwise. On the edge where it goes from all-ones to 0, ts_wrap_o=1 for exactly the following cycle.
- Capture runs only when enable_i=1. Grant classification in the sample cycle:
  - Zero: no action.
  - Exactly one bit set at [r][c]: push word {ts_current, r, c, polarity_i}. ts_current is the counter value before this edge's increment.
  - More than one bit set: no push; err_o=1 for the next cycle. drop_cnt_o is not affected.
- Encoding is combinational from gnt_i/polarity_i. The push is registered on the same edge; no other input pipeline.
- Latency: a grant in cycle N into an empty FIFO gives evt_valid_o=1 with that word in cycle N+1. There is no combinational bypass.
- Output handshake:
  - Pop occurs on an edge where evt_valid_o=1 and evt_ready_i=1.
  - While evt_valid_o=1 and evt_ready_i=0, evt_data_o is held stable.
  - evt_valid_o equals (fifo_count_o != 0).
  - evt_data_o is the head entry, or 0 when empty.
- Full:
  - Push with count=FIFO_DEPTH and no pop that cycle: event dropped, drop_cnt_o incremented, saturating at 255.
  - Push and pop in the same cycle while full: both occur, count unchanged, no drop.
- Empty: pop is impossible because evt_valid_o=0. A push into an empty FIFO gives count 1 next cycle.
- Simultaneous push and pop when not empty: count unchanged, order preserved (FIFO).
- Pointers wrap modulo FIFO_DEPTH.
- enable_i=0: gnt_i ignored and timestamp frozen; the FIFO continues to drain normally.
- Output state machine, 2 states:
  - EMPTY: fifo_count_o=0. Goes to HAVE_DATA on a push.
  - HAVE_DATA: count>0. Returns to EMPTY when a pop leaves count 0 with no simultaneous push.
  - evt_valid_o is asserted iff state is HAVE_DATA.

Test Plan:
1. Reset released, enable_i=1, single grant gnt_i[5][2]=1, polarity_i=1 at ts=0x0003 → next cycle evt_valid_o=1, evt_data_o={0x0003,3'd5,3'd2,1'b1}; accepted with ready=1; fifo_count_o returns to 0.
2. ready=0; 10 consecutive single grants (FIFO_DEPTH=8) → fifo_count_o=8, drop_cnt_o=2. Then ready=1 → exactly 8 words drained, oldest first, timestamps strictly increasing.
3. FIFO full with ready=1 and a grant in the same cycle → word accepted, count stays 8, drop_cnt_o unchanged.
4. gnt_i[1][1]=gnt_i[4][6]=1 → err_o pulses for 1 cycle, no push, fifo_count_o unchanged.
5. Timestamp preloaded by running 65535 cycles with enable_i=1 → ts_wrap_o pulses once as the counter goes 0xFFFF→0x0000. A grant the following cycle carries ts=0x0000.
6. reset_i asserted low with 3 events buffered and ready=0 → evt_valid_o=0 and fifo_count_o=0 immediately, without waiting for a clock edge. After release, a new grant yields ts=0x0000 on its event.

Source files
------------

// File: rtl/aer_event_encoder_if.sv
// Address-event output stream: valid/ready handshake carrying encoded event words.
interface aer_event_encoder_if #(
  parameter int unsigned EVT_WIDTH = 23
) ();
  logic                 evt_valid_o;
  logic [EVT_WIDTH-1:0] evt_data_o;
  logic                 evt_ready_i;

  modport master (output evt_valid_o, output evt_data_o, input evt_ready_i);
  modport slave  (input evt_valid_o, input evt_data_o, output evt_ready_i);
endinterface

// File: rtl/aer_event_encoder.sv
// Encodes one-hot arbiter grants into {ts, x, y, pol} words and buffers them
// in a FIFO streamed out over a valid/ready handshake.
module aer_event_encoder #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned X_WIDTH    = $clog2(ROWS),
  parameter int unsigned Y_WIDTH    = $clog2(COLS),
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned EVT_WIDTH  = TS_WIDTH + X_WIDTH + Y_WIDTH + 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic [ROWS-1:0][COLS-1:0]     gnt_i,
  input  logic                          polarity_i,
  aer_event_encoder_if.master           evt_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [7:0]                    drop_cnt_o,
  output logic                          err_o,
  output logic                          ts_wrap_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_EMPTY,
    ST_HAVE_DATA
  } state_e;

  state_e               state_q, state_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic                 ts_wrap_q, ts_wrap_d;
  logic                 err_q, err_d;
  logic [7:0]           drop_q, drop_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [EVT_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [1:0]           hit_cnt;
  logic [X_WIDTH-1:0]   gnt_x;
  logic [Y_WIDTH-1:0]   gnt_y;
  logic [EVT_WIDTH-1:0] evt_word;
  logic                 push_req, push, pop, full, drop;

  // Saturating hit counter: only 0 / 1 / many matters for classification.
  always_comb begin
    hit_cnt = 2'd0;
    gnt_x   = '0;
    gnt_y   = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (gnt_i[r][c]) begin
          if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
          gnt_x = X_WIDTH'(r);
          gnt_y = Y_WIDTH'(c);
        end
      end
    end
  end

  assign evt_word = {ts_q, gnt_x, gnt_y, polarity_i};
  assign push_req = enable_i && (hit_cnt == 2'd1);
  assign pop      = evt_if.evt_valid_o && evt_if.evt_ready_i;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    ts_d      = enable_i ? ts_q + 1'b1 : ts_q;
    ts_wrap_d = enable_i && (ts_q == '1);
    err_d     = enable_i && (hit_cnt == 2'd2);
    drop_d    = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    evt_if.evt_valid_o = 1'b0;
    evt_if.evt_data_o  = '0;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_HAVE_DATA;
      end
      ST_HAVE_DATA: begin
        evt_if.evt_valid_o = 1'b1;
        evt_if.evt_data_o  = mem_q[rd_ptr_q];
        if (pop && !push && count_q == CNT_W'(1)) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_EMPTY;
      ts_q      <= '0;
      ts_wrap_q <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      ts_wrap_q <= ts_wrap_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= evt_word;
    end
  end

  assign fifo_count_o = count_q;
  assign drop_cnt_o   = drop_q;
  assign err_o        = err_q;
  assign ts_wrap_o    = ts_wrap_q;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Bench for aer_event_encoder: directed scenarios plus random traffic against a queue model.
module tb_aer_event_encoder;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             enable = 1'b0;
  logic             pol = 1'b0;
  logic [7:0][7:0]  gnt = '0;
  logic [3:0]       fifo_count;
  logic [7:0]       drop_cnt;
  logic             err, ts_wrap;

  always #5 clk = ~clk;

  aer_event_encoder_if #(.EVT_WIDTH(23)) evt_if ();

  aer_event_encoder #(
    .ROWS(8), .COLS(8), .TS_WIDTH(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .enable_i(enable), .gnt_i(gnt),
    .polarity_i(pol), .evt_if(evt_if), .fifo_count_o(fifo_count),
    .drop_cnt_o(drop_cnt), .err_o(err), .ts_wrap_o(ts_wrap)
  );

  int checks = 0;
  int failures = 0;

  logic [22:0] q[$];
  int unsigned ts_m = 0, drop_m = 0;
  logic err_m = 1'b0, wrap_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(evt_if.evt_valid_o), 32'(q.size() != 0));
    chk("data", 32'(evt_if.evt_data_o), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("drop", 32'(drop_cnt), 32'(drop_m));
    chk("err", 32'(err), 32'(err_m));
    chk("ts_wrap", 32'(ts_wrap), 32'(wrap_m));
  endtask

  task automatic cycle(input logic en, input logic [7:0][7:0] g, input logic p, input logic rdy);
    int hits, rr, cc, old;
    logic popm;
    enable = en; gnt = g; pol = p; evt_if.evt_ready_i = rdy;
    @(posedge clk); #1;
    hits = 0; rr = 0; cc = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (g[r][c]) begin hits++; rr = r; cc = c; end
    old  = q.size();
    popm = (old != 0) && rdy;
    if (popm) void'(q.pop_front());
    err_m  = en && (hits > 1);
    wrap_m = en && (ts_m == 32'hFFFF);
    if (en && hits == 1) begin
      if (old < DEPTH || popm) q.push_back(23'((ts_m << 7) | (rr << 4) | (cc << 1) | 32'(p)));
      else if (drop_m < 255) drop_m++;
    end
    if (en) ts_m = (ts_m + 1) % 65536;
    check_model();
  endtask

  task automatic async_reset();
    @(negedge clk); #2;
    reset_n = 1'b0; #1;
    q.delete(); ts_m = 0; drop_m = 0; err_m = 1'b0; wrap_m = 1'b0;
    chk("rst_valid_immediate", 32'(evt_if.evt_valid_o), 32'd0);
    chk("rst_count_immediate", 32'(fifo_count), 32'd0);
    check_model();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0][7:0] one(input int r, input int c);
    logic [7:0][7:0] g;
    g = '0;
    g[r][c] = 1'b1;
    return g;
  endfunction

  function automatic logic [7:0][7:0] rand_one();
    return one(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
  endfunction

  initial begin
    logic [22:0] exp_word;
    logic [15:0] prev_ts, cur_ts;
    logic [7:0][7:0] g;
    int a, b;

    evt_if.evt_ready_i = 1'b0;
    async_reset();

    // 1: single grant at ts=3
    for (int i = 0; i < 3; i++) cycle(1'b1, '0, 1'b0, 1'b1);
    cycle(1'b1, one(5, 2), 1'b1, 1'b1);
    exp_word = {16'h0003, 3'd5, 3'd2, 1'b1};
    chk("t1_word", 32'(evt_if.evt_data_o), 32'(exp_word));
    chk("t1_valid", 32'(evt_if.evt_valid_o), 32'd1);
    cycle(1'b1, '0, 1'b0, 1'b1);
    chk("t1_count_after_pop", 32'(fifo_count), 32'd0);

    // 2: overflow by two, then drain oldest first
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_one(), 1'($urandom_range(0, 1)), 1'b0);
    chk("t2_count_full", 32'(fifo_count), 32'd8);
    chk("t2_drops", 32'(drop_cnt), 32'd2);
    prev_ts = evt_if.evt_data_o[22:7];
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, '0, 1'b0, 1'b1);
      if (i < 7) begin
        cur_ts = evt_if.evt_data_o[22:7];
        chk("t2_ts_increasing", 32'(cur_ts > prev_ts), 32'd1);
        prev_ts = cur_ts;
      end
    end
    chk("t2_drained", 32'(fifo_count), 32'd0);

    // 3: push and pop while full
    for (int i = 0; i < 8; i++) cycle(1'b1, rand_one(), 1'b0, 1'b0);
    cycle(1'b1, one(7, 7), 1'b1, 1'b1);
    chk("t3_count_stays_full", 32'(fifo_count), 32'd8);
    chk("t3_drop_unchanged", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 9; i++) cycle(1'b1, '0, 1'b0, 1'b1);

    // 4: multi-hot grant
    g = one(1, 1); g[4][6] = 1'b1;
    cycle(1'b1, g, 1'b0, 1'b0);
    chk("t4_err_pulse", 32'(err), 32'd1);
    chk("t4_no_push", 32'(fifo_count), 32'd0);
    cycle(1'b1, '0, 1'b0, 1'b0);
    chk("t4_err_clears", 32'(err), 32'd0);

    // 5: timestamp wrap
    while (ts_m != 32'hFFFF) cycle(1'b1, '0, 1'b0, 1'b1);
    cycle(1'b1, '0, 1'b0, 1'b1);
    chk("t5_wrap_pulse", 32'(ts_wrap), 32'd1);
    cycle(1'b1, one(2, 3), 1'b0, 1'b0);
    chk("t5_wrap_once", 32'(ts_wrap), 32'd0);
    chk("t5_ts_zero", 32'(evt_if.evt_data_o[22:7]), 32'd0);
    cycle(1'b1, '0, 1'b0, 1'b1);

    // 6: asynchronous reset with buffered events
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_one(), 1'b1, 1'b0);
    chk("t6_buffered", 32'(fifo_count), 32'd3);
    async_reset();
    cycle(1'b1, one(6, 1), 1'b1, 1'b0);
    chk("t6_ts_restart", 32'(evt_if.evt_data_o[22:7]), 32'd0);
    chk("t6_word", 32'(evt_if.evt_data_o), 32'({16'h0000, 3'd6, 3'd1, 1'b1}));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      g = '0;
      case ($urandom_range(0, 9))
        0, 1:    g = '0;
        9: begin
          a = int'($urandom_range(0, 63));
          b = (a + 1 + int'($urandom_range(0, 62))) % 64;
          g[a / 8][a % 8] = 1'b1;
          g[b / 8][b % 8] = 1'b1;
        end
        default: g = rand_one();
      endcase
      cycle($urandom_range(0, 7) != 0, g, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
